muldiv_iter: RTL

- Parametrised, multi-cycle successor to the single-cycle mul/div datapath in the execute stage.
- Implements the RV64M/RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, plus their W (word) forms.
- Multiplication is an iterative shift-add; division is radix-2 restoring.
- The execute stage sends it one request and stalls until the single response is accepted; a kill input aborts the operation on flush.

---
 rtl/muldiv_iter.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV64M/RV32M multiply/divide unit: shift-add multiplier, radix-2 restoring divider.
// One request in flight; the response is held until accepted or the operation is killed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; operands are prepared on acceptance
// MUL   | shift-add iterations, MUL_UNROLL multiplier bits per cycle
// DIV   | restoring divide iterations, one quotient bit per cycle
// DONE  | registered result presented until resp_ready (or kill)

module muldiv_iter #(
    parameter int XLEN       = 64,
    parameter int MUL_UNROLL = 4,
    parameter int EARLY_OUT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [CW-1:0] N_DIV_X = CW'(XLEN);
    localparam logic [CW-1:0] N_DIV_W = CW'(32);
    localparam logic [CW-1:0] N_MUL_X = CW'(XLEN / MUL_UNROLL);
    localparam logic [CW-1:0] N_MUL_W = CW'(32 / MUL_UNROLL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Reduce to the low 32 bits and sign/zero-extend when word is set.
    function automatic logic [XLEN-1:0] fit_w(input logic [XLEN-1:0] v,
                                              input logic word,
                                              input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        if (word) begin
            for (int i = 32; i < XLEN; i++) begin
                r[i] = sgn & v[31];
            end
        end
        return r;
    endfunction

    state_t state_q, state_d;

    logic [2:0]      op_q;
    logic            word_q;
    logic            neg_q;
    logic            neg_r;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   prod_q;
    logic [PW-1:0]   mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] resp_data_q;

    logic accept;

    // Request-side operand preparation
    logic            word_in;
    logic            sgn1_in;
    logic            sgn2_in;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            neg1_in;
    logic            neg2_in;
    logic [XLEN-1:0] mag1_in;
    logic [XLEN-1:0] mag2_in;
    logic [XLEN-1:0] min_w;
    logic            b_zero;
    logic            ovf_in;
    logic            early_in;
    logic [XLEN-1:0] early_res;
    logic            neg_q_in;
    logic            neg_r_in;
    logic [CW-1:0]   cnt_in;

    always_comb begin
        word_in   = (XLEN == 64) && req_word;
        sgn1_in   = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
        sgn2_in   = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
        a_ext     = fit_w(req_src1, word_in, sgn1_in);
        b_ext     = fit_w(req_src2, word_in, sgn2_in);
        neg1_in   = sgn1_in & a_ext[XLEN-1];
        neg2_in   = sgn2_in & b_ext[XLEN-1];
        mag1_in   = neg1_in ? -a_ext : a_ext;
        mag2_in   = neg2_in ? -b_ext : b_ext;
        min_w     = word_in ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
        b_zero    = (b_ext == '0);
        ovf_in    = sgn1_in && sgn2_in && (a_ext == min_w) && (b_ext == '1);
        early_in  = (EARLY_OUT != 0) && req_op[2] && (b_zero || ovf_in);

        early_res = '0;
        if (b_zero) begin
            early_res = req_op[1] ? fit_w(req_src1, word_in, 1'b1) : '1;
        end else if (ovf_in) begin
            early_res = req_op[1] ? '0 : fit_w(req_src1, word_in, 1'b1);
        end

        // A zero divisor must yield all-ones regardless of dividend sign.
        neg_q_in = 1'b0;
        if ((req_op == 3'd1) || (req_op == 3'd2)) begin
            neg_q_in = neg1_in ^ neg2_in;
        end else if (req_op == 3'd4) begin
            neg_q_in = (neg1_in ^ neg2_in) & ~b_zero;
        end
        neg_r_in = (req_op == 3'd6) & neg1_in;

        if (req_op[2]) begin
            cnt_in = word_in ? N_DIV_W : N_DIV_X;
        end else begin
            cnt_in = word_in ? N_MUL_W : N_MUL_X;
        end
    end

    // Multiply step and result selection
    logic [PW-1:0]   prod_step;
    logic [PW-1:0]   prod_fin;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_res;

    always_comb begin
        prod_step = prod_q;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            if (mplier_q[i]) begin
                prod_step = prod_step + (mcand_q << i);
            end
        end
        prod_fin = neg_q ? -prod_step : prod_step;
        mul_hi   = prod_fin[PW-1:XLEN];
        if (word_q) begin
            mul_hi[31:0] = prod_fin[63:32];
        end
        mul_res = fit_w((op_q == 3'd0) ? prod_fin[XLEN-1:0] : mul_hi, word_q, 1'b1);
    end

    // Restoring divide step; a W-form dividend sits in the low 32 bits of quo_q.
    logic            quo_msb;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] div_res;

    always_comb begin
        quo_msb  = word_q ? quo_q[31] : quo_q[XLEN-1];
        rem_sh   = {rem_q, quo_msb};
        rem_ge   = rem_sh >= {1'b0, dvsr_q};
        rem_step = rem_ge ? (rem_sh[XLEN-1:0] - dvsr_q) : rem_sh[XLEN-1:0];
        quo_step = {quo_q[XLEN-2:0], rem_ge};
        quo_fin  = neg_q ? -quo_step : quo_step;
        rem_fin  = neg_r ? -rem_step : rem_step;
        div_res  = fit_w(op_q[1] ? rem_fin : quo_fin, word_q, 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (early_in) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = req_op[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (kill || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            word_q      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= req_op;
                word_q   <= word_in;
                neg_q    <= neg_q_in;
                neg_r    <= neg_r_in;
                cnt_q    <= cnt_in;
                prod_q   <= '0;
                mcand_q  <= {{XLEN{1'b0}}, mag1_in};
                mplier_q <= mag2_in;
                quo_q    <= mag1_in;
                rem_q    <= '0;
                dvsr_q   <= mag2_in;
                if (early_in) begin
                    resp_data_q <= early_res;
                end
            end
            if ((state_q == S_MUL) && !kill) begin
                prod_q   <= prod_step;
                mcand_q  <= mcand_q << MUL_UNROLL;
                mplier_q <= mplier_q >> MUL_UNROLL;
                cnt_q    <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    resp_data_q <= mul_res;
                end
            end
            if ((state_q == S_DIV) && !kill) begin
                quo_q <= quo_step;
                rem_q <= rem_step;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    resp_data_q <= div_res;
                end
            end
        end
    end

    assign resp_data = resp_data_q;

endmodule
